// File: rtl/scmp_regs_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : scmp_regs_pkg
//  Brief   : SR bit positions and DAD sequencer state encoding for scmp_acc_sr.
//  Revision: 1.0
// ============================================================================
package scmp_regs_pkg;

    localparam int SR_CY = 7;
    localparam int SR_OV = 6;
    localparam int SR_SB = 5;
    localparam int SR_SA = 4;
    localparam int SR_IE = 3;

    typedef enum logic [1:0] {
        DAD_IDLE = 2'd0,
        DAD_LO   = 2'd1,
        DAD_HI   = 2'd2
    } dad_state_t;

endpackage
`default_nettype wire

// File: rtl/scmp_bcd_digit.sv
`default_nettype none
// ============================================================================
//  Module  : scmp_bcd_digit
//  Brief   : One BCD digit add with the >9 (+6) correction; non-BCD inputs wrap in 4 bits.
//  Revision: 1.0
// ============================================================================
module scmp_bcd_digit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] d_o,
    output logic       c_o
);

    logic [4:0] w_sum;

    always_comb begin
        w_sum = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, c_i};
        if (w_sum > 5'd9) begin
            d_o = w_sum[3:0] + 4'd6;
            c_o = 1'b1;
        end else begin
            d_o = w_sum[3:0];
            c_o = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/scmp_acc_sr.sv
`default_nettype none
// ============================================================================
//  Module  : scmp_acc_sr
//  Brief   : SC/MP AC/E/SR register stage with two-step decimal add, serial E I/O and sense sync.
//  Revision: 1.0
// ============================================================================
module scmp_acc_sr
    import scmp_regs_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] alu_res,
    input  logic       alu_cy,
    input  logic       alu_ov,
    input  logic [7:0] bus_i,
    input  logic       ld_ac,
    input  logic       ld_flags,
    input  logic       ld_e,
    input  logic       ld_sr,
    input  logic       sio,
    input  logic       sin,
    output logic       sout,
    input  logic       dad_start,
    input  logic [7:0] dad_op,
    output logic       dad_busy,
    output logic       dad_done,
    input  logic       sa_i,
    input  logic       sb_i,
    output logic [7:0] ac_o,
    output logic [7:0] e_o,
    output logic [7:0] sr_o,
    output logic       cy_o,
    output logic       ov_o,
    output logic       ie_o,
    output logic [2:0] flags_o
);

    dad_state_t state_q, state_d;

    logic [7:0] ac_q, ac_d;
    logic [7:0] e_q, e_d;
    logic       cy_q, cy_d;
    logic       ov_q, ov_d;
    logic       ie_q, ie_d;
    logic [2:0] f_q, f_d;
    logic [7:0] op_q;
    logic [3:0] lo_q;
    logic       dc_q;
    logic       done_q;

    logic [SYNC_STAGES-1:0] sa_sync_q, sb_sync_q;

    logic       w_busy;
    logic [3:0] w_a, w_b, w_d;
    logic       w_cin, w_cout;
    logic       w_unused;

    assign w_unused = &{1'b0, bus_i[SR_SB], bus_i[SR_SA]};

    // ---------------- DAD sequencer: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= DAD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- DAD sequencer: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            DAD_IDLE: if (dad_start) state_d = DAD_LO;
            DAD_LO:   state_d = DAD_HI;
            DAD_HI:   state_d = DAD_IDLE;
            default:  state_d = DAD_IDLE;
        endcase
    end

    // ---------------- DAD sequencer: outputs ----------------
    always_comb begin
        w_busy   = (state_q != DAD_IDLE);
        dad_busy = w_busy;
        dad_done = done_q;
    end

    // Single digit adder shared by both steps: low digit uses CY, high digit the low carry
    always_comb begin
        w_a   = ac_q[3:0];
        w_b   = op_q[3:0];
        w_cin = cy_q;
        if (state_q == DAD_HI) begin
            w_a   = ac_q[7:4];
            w_b   = op_q[7:4];
            w_cin = dc_q;
        end
    end

    scmp_bcd_digit u_digit (
        .a_i (w_a),
        .b_i (w_b),
        .c_i (w_cin),
        .d_o (w_d),
        .c_o (w_cout)
    );

    always_comb begin
        ac_d = ac_q;
        cy_d = cy_q;
        ov_d = ov_q;
        ie_d = ie_q;
        f_d  = f_q;
        e_d  = e_q;
        // AC and CY stay frozen while a DAD owns them
        if (state_q == DAD_HI) begin
            ac_d = {w_d, lo_q};
            cy_d = w_cout;
        end else if (!w_busy) begin
            if (ld_ac) ac_d = alu_res;
            if (ld_sr)         cy_d = bus_i[SR_CY];
            else if (ld_flags) cy_d = alu_cy;
        end
        if (ld_sr)         ov_d = bus_i[SR_OV];
        else if (ld_flags) ov_d = alu_ov;
        if (ld_sr) begin
            ie_d = bus_i[SR_IE];
            f_d  = bus_i[2:0];
        end
        if (ld_e)     e_d = bus_i;
        else if (sio) e_d = {sin, e_q[7:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ac_q      <= 8'h00;
            e_q       <= 8'h00;
            cy_q      <= 1'b0;
            ov_q      <= 1'b0;
            ie_q      <= 1'b0;
            f_q       <= 3'b000;
            op_q      <= 8'h00;
            lo_q      <= 4'h0;
            dc_q      <= 1'b0;
            done_q    <= 1'b0;
            sa_sync_q <= '0;
            sb_sync_q <= '0;
        end else begin
            ac_q      <= ac_d;
            e_q       <= e_d;
            cy_q      <= cy_d;
            ov_q      <= ov_d;
            ie_q      <= ie_d;
            f_q       <= f_d;
            if (state_q == DAD_IDLE && dad_start) op_q <= dad_op;
            if (state_q == DAD_LO) begin
                lo_q <= w_d;
                dc_q <= w_cout;
            end
            done_q    <= (state_q == DAD_HI);
            sa_sync_q <= {sa_sync_q[SYNC_STAGES-2:0], sa_i};
            sb_sync_q <= {sb_sync_q[SYNC_STAGES-2:0], sb_i};
        end
    end

    always_comb begin
        sr_o        = 8'h00;
        sr_o[SR_CY] = cy_q;
        sr_o[SR_OV] = ov_q;
        sr_o[SR_SB] = sb_sync_q[SYNC_STAGES-1];
        sr_o[SR_SA] = sa_sync_q[SYNC_STAGES-1];
        sr_o[SR_IE] = ie_q;
        sr_o[2:0]   = f_q;
    end

    assign ac_o    = ac_q;
    assign e_o     = e_q;
    assign sout    = e_q[0];
    assign cy_o    = cy_q;
    assign ov_o    = ov_q;
    assign ie_o    = ie_q;
    assign flags_o = f_q;

endmodule
`default_nettype wire
